// File: rtl/busqueda_pkg.sv
// Shared types and constants for the busqueda_sar8 successive-approximation search.
// Build option: BUSQUEDA_SIGNED_EN selects a two's-complement search range (-128..127).
// Without it, the search covers the unsigned range 0..255.
package busqueda_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The search always runs on an offset-binary value. XOR with OFS maps that value
  // onto the number range the paired comparator uses.
`ifdef BUSQUEDA_SIGNED_EN
  localparam logic [W-1:0] OFS = 8'h80;
`else
  localparam logic [W-1:0] OFS = 8'h00;
`endif

endpackage

// File: rtl/busqueda_sar8.sv
// Purpose: recovers the comparator's hidden "a" operand by driving its "b" input
//          (probe) bit by bit, MSB first, and then runs one verify step.
// Latency: done pulses 9*SETTLE+1 cycles after start, or earlier on a flag fault.
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise (no queuing).
// Build option: BUSQUEDA_SIGNED_EN (see busqueda_pkg) selects the signed range.
module busqueda_sar8
  import busqueda_pkg::*;
#(
  parameter int unsigned SETTLE = 1  // cycles each probe is held; legal range 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         igual,
  input  logic         mayor,
  input  logic         menor,
  output logic [W-1:0] probe,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         fault,
  output logic [W-1:0] result
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t         state, state_nx;
  logic [W-1:0]   sar, sar_nx;
  logic [2:0]     idx, idx_nx;
  logic [3:0]     cnt, cnt_nx;
  logic [W-1:0]   probe_nx;
  logic           found_nx, fault_nx;
  logic [W-1:0]   result_nx;

  logic           flags_ok;
  logic [W-1:0]   bit_cur, bit_nxt, sar_upd;

  // Flags are only meaningful when exactly one of them is set.
  always_comb begin
    flags_ok = 1'b0;
    case ({igual, mayor, menor})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  // Trial bit of the current step, trial bit of the next step, and the decided SAR value.
  always_comb begin
    bit_cur = W'(1) << idx;
    bit_nxt = W'(1) << (idx - 3'd1);
    sar_upd = (igual | mayor) ? (sar | bit_cur) : sar;
  end

  // Next-state and next-output logic for the search sequencer.
  always_comb begin
    state_nx  = state;
    sar_nx    = sar;
    idx_nx    = idx;
    cnt_nx    = cnt;
    probe_nx  = probe;
    found_nx  = found;
    fault_nx  = fault;
    result_nx = result;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = PROBE;
          sar_nx    = '0;
          idx_nx    = 3'd7;
          cnt_nx    = SETTLE_M1;
          probe_nx  = 8'h80 ^ OFS;
          found_nx  = 1'b0;
          fault_nx  = 1'b0;
          result_nx = '0;
        end
      end
      PROBE: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else if (!flags_ok) begin
          fault_nx  = 1'b1;
          found_nx  = 1'b0;
          result_nx = '0;
          state_nx  = DONE;
        end else begin
          sar_nx = sar_upd;
          cnt_nx = SETTLE_M1;
          if (idx == 3'd0) begin
            state_nx = CHECK;
            probe_nx = sar_upd ^ OFS;
          end else begin
            idx_nx   = idx - 3'd1;
            probe_nx = (sar_upd | bit_nxt) ^ OFS;
          end
        end
      end
      CHECK: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else if (!flags_ok) begin
          fault_nx  = 1'b1;
          found_nx  = 1'b0;
          result_nx = '0;
          state_nx  = DONE;
        end else begin
          found_nx  = igual;
          fault_nx  = ~igual;
          result_nx = sar ^ OFS;
          state_nx  = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any search in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sar    <= '0;
      idx    <= 3'd7;
      cnt    <= '0;
      probe  <= '0;
      found  <= 1'b0;
      fault  <= 1'b0;
      result <= '0;
    end else begin
      state  <= state_nx;
      sar    <= sar_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      probe  <= probe_nx;
      found  <= found_nx;
      fault  <= fault_nx;
      result <= result_nx;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_busqueda_sar8.sv
// Directed bench for busqueda_sar8: two instances (SETTLE=1 and SETTLE=3), each
// paired with a behavioural model of the Comparador8bits comparator holding the target.
module tb_busqueda_sar8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       start1, start3;
  logic [7:0] target1, target3;
  logic       fz1;
  logic       igual1, mayor1, menor1, igual3, mayor3, menor3;
  logic [7:0] probe1, probe3, result1, result3;
  logic       busy1, done1, found1, fault1, busy3, done3, found3, fault3;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] probe_log [0:15];
  logic       busy_log  [0:15];
  logic       fault_log [0:15];

  always #5 clk = ~clk;

  // Comparator models: target on "a", DUT probe on "b". fz1 forces all flags low.
`ifdef BUSQUEDA_SIGNED_EN
  assign mayor1 = !fz1 && ($signed(target1) > $signed(probe1));
  assign menor1 = !fz1 && ($signed(target1) < $signed(probe1));
  assign mayor3 = $signed(target3) > $signed(probe3);
  assign menor3 = $signed(target3) < $signed(probe3);
`else
  assign mayor1 = !fz1 && (target1 > probe1);
  assign menor1 = !fz1 && (target1 < probe1);
  assign mayor3 = target3 > probe3;
  assign menor3 = target3 < probe3;
`endif
  assign igual1 = !fz1 && (target1 == probe1);
  assign igual3 = target3 == probe3;

  busqueda_sar8 #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .igual(igual1), .mayor(mayor1), .menor(menor1),
    .probe(probe1), .busy(busy1), .done(done1),
    .found(found1), .fault(fault1), .result(result1)
  );

  busqueda_sar8 #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .igual(igual3), .mayor(mayor3), .menor(menor3),
    .probe(probe3), .busy(busy3), .done(done3),
    .found(found3), .fault(fault3), .result(result3)
  );

  // Starts a search on instance 1 or 3 and returns the cycle (relative to T0) with done high,
  // or -1 if done never came. Optionally pulses start again at cycle pulse_at.
  task automatic run_search(input int which, input logic [7:0] tgt, input int pulse_at,
                            output int cyc);
    cyc = -1;
    @(negedge clk);
    if (which == 1) begin target1 = tgt; start1 = 1'b1; end
    else begin target3 = tgt; start3 = 1'b1; end
    @(posedge clk);
    for (int n = 1; n <= 100 && cyc < 0; n++) begin
      @(negedge clk);
      start1 = (which == 1) && (n == pulse_at);
      start3 = (which == 3) && (n == pulse_at);
      if (n < 16) begin
        probe_log[n] = (which == 1) ? probe1 : probe3;
        busy_log[n]  = (which == 1) ? busy1  : busy3;
        fault_log[n] = (which == 1) ? fault1 : fault3;
      end
      if ((which == 1) ? done1 : done3) cyc = n;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({probe1, result1} !== 16'h0) begin n_bad++; $display("FAIL reset_data: probe=%h result=%h, required 00/00", probe1, result1); end
    n_cmp++; if ({busy1, done1, found1, fault1} !== 4'b0) begin n_bad++; $display("FAIL reset_flags1: busy/done/found/fault=%b, required 0000", {busy1, done1, found1, fault1}); end
    n_cmp++; if ({busy3, done3, found3, fault3, probe3, result3} !== 20'h0) begin n_bad++; $display("FAIL reset_u3: got %h, required 0", {busy3, done3, found3, fault3, probe3, result3}); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifndef BUSQUEDA_SIGNED_EN
  task automatic test_unsigned_22;
    int cyc;
    logic [7:0] exp_seq [1:9];
    exp_seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h18, 8'h14, 8'h16, 8'h17, 8'h16};
    run_search(1, 8'd22, 0, cyc);
    n_cmp++; if (cyc !== 10) begin n_bad++; $display("FAIL t22_done_cycle: got %0d, required 10", cyc); end
    for (int k = 1; k <= 9; k++) begin
      n_cmp++; if (probe_log[k] !== exp_seq[k]) begin n_bad++; $display("FAIL t22_probe[%0d]: got %h, required %h", k, probe_log[k], exp_seq[k]); end
    end
    n_cmp++; if (busy_log[1] !== 1'b1) begin n_bad++; $display("FAIL t22_busy_first: got %b, required 1", busy_log[1]); end
    n_cmp++; if ({result1, found1, fault1} !== {8'd22, 2'b10}) begin n_bad++; $display("FAIL t22_outcome: result=%h found=%b fault=%b, required 16/1/0", result1, found1, fault1); end
    @(negedge clk);
    n_cmp++; if ({done1, busy1} !== 2'b00) begin n_bad++; $display("FAIL t22_after_done: done/busy=%b, required 00", {done1, busy1}); end
    n_cmp++; if ({result1, found1} !== {8'd22, 1'b1}) begin n_bad++; $display("FAIL t22_held: result=%h found=%b, required 16/1", result1, found1); end
  endtask

  task automatic test_edges;
    int cyc;
    run_search(1, 8'd0, 0, cyc);
    n_cmp++; if ({cyc == 10, result1, found1, fault1} !== {1'b1, 8'h00, 2'b10}) begin n_bad++; $display("FAIL edge0: cyc=%0d result=%h found=%b fault=%b, required 10/00/1/0", cyc, result1, found1, fault1); end
    run_search(1, 8'd255, 0, cyc);
    n_cmp++; if ({cyc == 10, result1, found1, fault1} !== {1'b1, 8'hFF, 2'b10}) begin n_bad++; $display("FAIL edge255: cyc=%0d result=%h found=%b fault=%b, required 10/FF/1/0", cyc, result1, found1, fault1); end
    n_cmp++; if (probe_log[9] !== 8'hFF) begin n_bad++; $display("FAIL edge255_check_probe: got %h, required FF", probe_log[9]); end
  endtask
`else
  task automatic test_signed;
    int cyc;
    run_search(1, 8'hFA, 0, cyc);
    n_cmp++; if (probe_log[1] !== 8'h00) begin n_bad++; $display("FAIL sgn_first_probe: got %h, required 00", probe_log[1]); end
    n_cmp++; if ({cyc == 10, result1, found1, fault1} !== {1'b1, 8'hFA, 2'b10}) begin n_bad++; $display("FAIL sgn_m6: cyc=%0d result=%h found=%b fault=%b, required 10/FA/1/0", cyc, result1, found1, fault1); end
    run_search(1, 8'h80, 0, cyc);
    n_cmp++; if ({cyc == 10, result1, found1, fault1} !== {1'b1, 8'h80, 2'b10}) begin n_bad++; $display("FAIL sgn_m128: cyc=%0d result=%h found=%b fault=%b, required 10/80/1/0", cyc, result1, found1, fault1); end
    run_search(1, 8'h7F, 0, cyc);
    n_cmp++; if ({cyc == 10, result1, found1} !== {1'b1, 8'h7F, 1'b1}) begin n_bad++; $display("FAIL sgn_p127: cyc=%0d result=%h found=%b, required 10/7F/1", cyc, result1, found1); end
  endtask
`endif

  task automatic test_fault;
    int cyc;
    fz1 = 1'b1;
    run_search(1, 8'd22, 0, cyc);
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL fault_done_cycle: got %0d, required 2", cyc); end
    n_cmp++; if ({fault1, found1, result1} !== {2'b10, 8'h00}) begin n_bad++; $display("FAIL fault_outcome: fault=%b found=%b result=%h, required 1/0/00", fault1, found1, result1); end
    fz1 = 1'b0;
    @(negedge clk);
    n_cmp++; if (fault1 !== 1'b1) begin n_bad++; $display("FAIL fault_held: got %b, required 1", fault1); end
    run_search(1, 8'd22, 0, cyc);
    n_cmp++; if (fault_log[1] !== 1'b0) begin n_bad++; $display("FAIL fault_cleared_on_start: got %b, required 0", fault_log[1]); end
    n_cmp++; if ({cyc == 10, result1, found1, fault1} !== {1'b1, 8'd22, 2'b10}) begin n_bad++; $display("FAIL fault_recover: cyc=%0d result=%h found=%b fault=%b, required 10/16/1/0", cyc, result1, found1, fault1); end
  endtask

  task automatic test_settle3;
    int cyc;
    run_search(3, 8'd40, 0, cyc);
    n_cmp++; if (cyc !== 28) begin n_bad++; $display("FAIL s3_done_cycle: got %0d, required 28", cyc); end
    n_cmp++; if ({result3, found3, fault3} !== {8'd40, 2'b10}) begin n_bad++; $display("FAIL s3_outcome: result=%h found=%b fault=%b, required 28/1/0", result3, found3, fault3); end
    n_cmp++; if ({probe_log[1], probe_log[3], probe_log[4]} !== {8'h80, 8'h80, 8'h40}) begin n_bad++; $display("FAIL s3_hold: probes c1/c3/c4=%h/%h/%h, required 80/80/40", probe_log[1], probe_log[3], probe_log[4]); end
  endtask

  task automatic test_ignore_start;
    int cyc;
    logic idle_ok;
    run_search(1, 8'd22, 4, cyc);
    n_cmp++; if ({cyc == 10, result1} !== {1'b1, 8'd22}) begin n_bad++; $display("FAIL ign_run: cyc=%0d result=%h, required 10/16", cyc, result1); end
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy1 || done1) idle_ok = 1'b0;
    end
    n_cmp++; if (idle_ok !== 1'b1) begin n_bad++; $display("FAIL ign_no_queue: busy/done seen after search, got %b, required 1", idle_ok); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic no_done;
    @(negedge clk);
    target3 = 8'd40; start3 = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    start3 = 1'b0;
    n_cmp++; if (busy3 !== 1'b1) begin n_bad++; $display("FAIL rm_running: busy=%b, required 1", busy3); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy3, done3, found3, fault3, probe3, result3} !== 20'h0) begin n_bad++; $display("FAIL rm_immediate: busy=%b done=%b found=%b fault=%b probe=%h result=%h, required all 0", busy3, done3, found3, fault3, probe3, result3); end
    no_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done3 || busy3) no_done = 1'b0;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done3 || busy3) no_done = 1'b0;
    end
    n_cmp++; if (no_done !== 1'b1) begin n_bad++; $display("FAIL rm_no_done: done/busy seen after reset, got %b, required 1", no_done); end
    run_search(3, 8'd40, 0, cyc);
    n_cmp++; if ({cyc == 28, result3, found3, fault3} !== {1'b1, 8'd40, 2'b10}) begin n_bad++; $display("FAIL rm_recover: cyc=%0d result=%h found=%b fault=%b, required 28/28/1/0", cyc, result3, found3, fault3); end
  endtask

  initial begin
    start1 = 1'b0; start3 = 1'b0;
    target1 = 8'd0; target3 = 8'd0;
    fz1 = 1'b0;
    test_reset();
`ifndef BUSQUEDA_SIGNED_EN
    test_unsigned_22();
    test_edges();
`else
    test_signed();
`endif
    test_fault();
    test_settle3();
    test_ignore_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/busqueda_sar8.md
# busqueda_sar8

Sequential successive-approximation search engine that drives the 8-bit magnitude comparator `Comparador8bits` from the opposite side.
- The comparator's `a` input carries an unknown target.
- This block drives the comparator's `b` input (`probe`) and reads back `igual`/`mayor`/`menor`.
- It recovers the target value in 8 probe steps, then runs one verify step.
- It sits beside the comparator in the datapath and lets a controller read a value through the comparator.

## Interface
Parameters:
- SETTLE, default 1, cycles each probe value is held before flags are sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a search; sampled only in IDLE.
- igual  in  1  comparator flag: target == probe.
- mayor  in  1  comparator flag: target > probe.
- menor  in  1  comparator flag: target < probe.
- probe  out  8  value driven to the comparator `b` input; registered.
- busy  out  1  high from the cycle after start until DONE exits.
- done  out  1  one-cycle pulse at the end of a search.
- found  out  1  verify step saw `igual`; held until next start.
- fault  out  1  flag set not one-hot at a sample, or verify failed; held until next start.
- result  out  8  recovered value; held until next start.

## Operation
- States: IDLE, PROBE, CHECK, DONE.
- IDLE with start=1:
  - go to PROBE.
  - sar=8'h00, bit index i=7.
  - clear found, fault and result.
- PROBE:
  - probe = (sar | 1<<i) ^ OFS.
  - OFS = 8'h00 unsigned, 8'h80 signed.
  - Hold for SETTLE cycles, then sample the flags on the last cycle.
  - If (igual|mayor), keep bit i in sar; if menor, clear it.
  - If i==0, go to CHECK; otherwise decrement i.
- CHECK:
  - probe = sar ^ OFS, held SETTLE cycles.
  - At the sample: found=igual, fault=~igual, result=sar ^ OFS.
  - Go to DONE.
- Fault rule: at any sample, if the flags are not exactly one-hot:
  - fault=1, found=0, result=8'h00.
  - go straight to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- start outside IDLE is ignored. No queuing.
- Reset values: probe=0, busy=0, done=0, found=0, fault=0, result=0. State is IDLE.
- Reset mid-search aborts immediately. No done pulse is issued.

## Timing
- Let start be high at rising edge T0.
- PROBE for bit 7 begins in cycle T0+1. probe is valid from T0+1.
- Each step lasts SETTLE cycles: 8 PROBE steps plus 1 CHECK step = 9·SETTLE cycles.
- done is high in cycle T0+9·SETTLE+1. With SETTLE=1, done is high in cycle T0+10.
- busy is high from T0+1 through the DONE cycle inclusive.
- A fault at step k (0-based) gives done at T0+(k+1)·SETTLE+1.
- The comparator is combinational, so flags are valid within the same cycle probe changes. SETTLE>1 covers a registered or off-chip comparator.
- A new start can be accepted in the cycle after DONE. Back-to-back period is 9·SETTLE+2 cycles.

## Configuration
- Macro `BUSQUEDA_SIGNED_EN`.
- Defined:
  - OFS=8'h80, so the search covers two's-complement −128..127.
  - The paired comparator must compare signed.
  - result is the two's-complement target.
- Undefined:
  - OFS=8'h00, so the search covers unsigned 0..255.

## Structure
- Package `busqueda_pkg` holds:
  - state enum {IDLE, PROBE, CHECK, DONE}.
  - localparam W=8.
  - OFS constant selected by the macro.
- Single module, no sub-module.
  - The SETTLE down-counter and bit index live in the FSM.
  - The bench pairs the block with `Comparador8bits` as the target model.

## Test plan
- Unsigned, SETTLE=1, target 22 → probe sequence 0x80, 0x40, 0x20, 0x10, 0x18, 0x14, 0x16, 0x17, then 0x16 (CHECK). done at T0+10, result=22, found=1, fault=0.
- Unsigned edge targets:
  - 0 → result 0x00, found=1.
  - 255 → result 0xFF, found=1.
- Signed build (BUSQUEDA_SIGNED_EN), target −6 → result 0xFA, found=1. Target −128 → result 0x80.
- Fault: hold igual, mayor and menor all at 0 → fault=1, found=0, result=0, done at T0+2 (SETTLE=1).
- Robustness:
  - SETTLE=3, target 40 → done at T0+28, result 40.
  - start pulsed while busy → ignored.
  - rst_n low mid-search → all outputs return to 0 at once, no done pulse; next start recovers 40.
